// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the hazard controller FSM states.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  // Hazard controller states. DWAIT marks a MEM request still waiting on dhit;
  // HALT is absorbing until reset.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  // True when a producer destination collides with either ID source register.
  // r0 is hardwired to zero and never creates a dependency.
  function automatic logic raw_match(input regbits_t rd,
                                     input regbits_t rs,
                                     input regbits_t rt);
    return (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter, either saturating at all-ones or wrapping modulo 2^CNT_W.
module sat_counter #(
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  // Next count: hold when idle, or when saturating and already at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(SATURATE && at_max)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, memory wait freezes,
// redirect squashes and terminal halt for the 5-stage datapath.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  regbits_t         ex_rd,
  input  logic             ex_memRd,
  input  logic             ex_regWr,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state_q;
  state_t state_d;

  logic dfreeze;
  logic lduse;
  logic halt_now;
  logic squash;
  logic stall_inc;

  assign dfreeze = (mem_dREN | mem_dWEN) & ~dhit;
  assign lduse   = ex_memRd & ex_regWr & raw_match(ex_rd, id_rs, id_rt);

  // Halt takes effect combinationally in the wb_halt cycle, then via state.
  assign halt_now = (state_q == HALT) | wb_halt;

  // Next state: halt dominates from anywhere; otherwise track the data wait.
  always_comb begin
    state_d = state_q;
    if (wb_halt) begin
      state_d = HALT;
    end else begin
      case (state_q)
        RUN:     if (dfreeze) state_d = DWAIT;
        DWAIT:   if (dhit)    state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // Priority mux for enables/flushes; reset forces the no-hazard pattern.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;
    squash      = 1'b0;
    if (!nRST) begin
      // Latches reset on their own; present a plain running pipe meanwhile.
    end else if (halt_now) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (dfreeze) begin
      // Whole pipe holds while the data access is outstanding.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (redirect) begin
      // PC takes the target even without ihit; wrong-path work is squashed,
      // which also covers any coincident load-use or fetch stall.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      squash      = 1'b1;
    end else if (lduse) begin
      // One bubble suffices: next cycle the load is in MEM and gets forwarded.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      // Fetch not ready: hold PC, bubble into ID, let older work drain.
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign stall_inc = nRST & ~pc_en & ~halted;

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (1'b0)
  ) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc_i (squash),
    .cnt_o (flush_cnt)
  );

endmodule
